instr_issuer: RTL and testbench

INSTR_ISSUER -- requirements
Module: instr_issuer

---
 rtl/instr_issuer_pkg.sv | 58 +++++
 rtl/issue_fifo.sv | 57 +++++
 rtl/instr_issuer.sv | 127 ++++++++++++
 tb/tb_instr_issuer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the instruction issuer: opcodes, the queued command
// layout, FSM states and instruction word field positions.
package instr_issuer_pkg;

    // Opcode byte values as seen by the processor
    localparam logic [7:0] OP_AND   = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_FETCH = 8'h02;
    localparam logic [7:0] OP_NOP   = 8'hFF;

    // Host encoding 3 is reserved: accepted on the handshake, then dropped
    localparam logic [1:0] ENC_OP_RSVD = 2'd3;

    // Instruction word field positions
    localparam int FIELD_W  = 8;
    localparam int OPC_LSB  = 24;
    localparam int DST_LSB  = 16;
    localparam int SRCB_LSB = 8;
    localparam int SRCA_LSB = 0;

    // One queued command, 26 bits
    typedef struct packed {
        logic [1:0] op;
        logic [7:0] dst;
        logic [7:0] src_b;
        logic [7:0] src_a;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Real instruction word for a queued command
    function automatic logic [31:0] make_instr(input cmd_t c);
        logic [31:0] w;
        w = '0;
        w[OPC_LSB  +: FIELD_W] = {6'b0, c.op};
        w[DST_LSB  +: FIELD_W] = c.dst;
        w[SRCB_LSB +: FIELD_W] = c.src_b;
        w[SRCA_LSB +: FIELD_W] = c.src_a;
        return w;
    endfunction

    // Bubble word: ignored opcode that rewrites the last result in place
    function automatic logic [31:0] make_bubble(input logic [7:0] last_dst);
        logic [31:0] w;
        w = '0;
        w[OPC_LSB +: FIELD_W] = OP_NOP;
        w[DST_LSB +: FIELD_W] = last_dst;
        return w;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Command FIFO for the issuer: power-of-two depth, wrapping pointers,
// show-ahead read port, push-while-full allowed when popping the same cycle.
module issue_fifo #(
    parameter int DATA_W = 26,
    parameter int DEPTH  = 8,
    parameter int LVL_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy tracking; reset empties the queue at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are meaningless once the pointers are reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: queues host commands and feeds them to the processor
// one per cycle, inserting a bubble on a FETCH-after-write hazard and
// draining two cycles before reporting done.
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enc_valid,
    output logic        enc_ready,
    input  logic [1:0]  enc_op,
    input  logic [7:0]  enc_dst,
    input  logic [7:0]  enc_src_b,
    input  logic [7:0]  enc_src_a,
    input  logic        run,
    output logic [31:0] instr,
    output logic        busy,
    output logic        done,
    output logic [4:0]  level,
    output logic [7:0]  issued_cnt
);

    state_t            state;
    state_t            state_nxt;
    cmd_t              enc_cmd;
    cmd_t              head;
    logic [CMD_W-1:0]  head_bits;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              hazard;
    logic              drain_last;
    logic              vld_p1;
    logic [7:0]        last_dst;
    logic [31:0]       instr_p1;

    assign enc_cmd   = cmd_t'({enc_op, enc_dst, enc_src_b, enc_src_a});
    assign head      = cmd_t'(head_bits);
    // A pop frees a slot in the same cycle, so a full queue can still take a push
    assign enc_ready = !fifo_full || pop;
    assign push      = enc_valid && enc_ready && (enc_op != ENC_OP_RSVD);
    // Only a real instruction in the output stage can cause a hazard
    assign hazard    = vld_p1 && (head.op == OP_FETCH[1:0]) && (head.src_a == last_dst);
    assign instr     = instr_p1;

    issue_fifo #(
        .DATA_W (CMD_W),
        .DEPTH  (DEPTH),
        .LVL_W  (5)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (enc_cmd),
        .pop   (pop),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // State register plus drain-cycle marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            drain_last <= 1'b0;
        end else begin
            state      <= state_nxt;
            drain_last <= (state == ST_DRAIN);
        end
    end

    // Next-state, pop decision and status outputs
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run && !fifo_empty) state_nxt = ST_ISSUE;
            end
            ST_ISSUE, ST_BUBBLE: begin
                busy = 1'b1;
                if (fifo_empty || !run) begin
                    state_nxt = ST_DRAIN;
                end else if (hazard) begin
                    state_nxt = ST_BUBBLE;
                end else begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_last) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output stage p1: popped command or bubble word, last destination, count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1   <= make_bubble(8'h00);
            vld_p1     <= 1'b0;
            last_dst   <= 8'h00;
            issued_cnt <= 8'h00;
        end else begin
            vld_p1 <= pop;
            if (pop) begin
                instr_p1   <= make_instr(head);
                last_dst   <= head.dst;
                issued_cnt <= issued_cnt + 8'd1;
            end else begin
                instr_p1   <= make_bubble(last_dst);
            end
        end
    end

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer with a small processor storage model.
module tb_instr_issuer;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        enc_valid;
    logic        enc_ready;
    logic [1:0]  enc_op;
    logic [7:0]  enc_dst;
    logic [7:0]  enc_src_b;
    logic [7:0]  enc_src_a;
    logic        run;
    logic [31:0] instr;
    logic        busy;
    logic        done;
    logic [4:0]  level;
    logic [7:0]  issued_cnt;

    int tests = 0;
    int fails = 0;

    logic [7:0] pmem [256];

    instr_issuer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enc_valid  (enc_valid),
        .enc_ready  (enc_ready),
        .enc_op     (enc_op),
        .enc_dst    (enc_dst),
        .enc_src_b  (enc_src_b),
        .enc_src_a  (enc_src_a),
        .run        (run),
        .instr      (instr),
        .busy       (busy),
        .done       (done),
        .level      (level),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Processor model: executes the word held on instr during each cycle
    always @(posedge clk) begin
        if (rst_n) begin
            case (instr[31:24])
                8'h00: pmem[instr[23:16]] = instr[7:0] & instr[15:8];
                8'h01: pmem[instr[23:16]] = instr[7:0] + instr[15:8];
                8'h02: pmem[instr[23:16]] = pmem[instr[7:0]];
                default: ;
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] dst,
                        input logic [7:0] b, input logic [7:0] a);
        enc_valid = 1'b1;
        enc_op    = op;
        enc_dst   = dst;
        enc_src_b = b;
        enc_src_a = a;
        tick();
        enc_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            if (done === 1'b1) got = 1'b1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s: no done pulse within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset;
        repeat (2) tick();
        tests++; if (instr !== 32'hFF00_0000) begin fails++; $display("FAIL rst_instr: got %h want ff000000", instr); end
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL rst_level: got %0d want 0", level); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
        tests++; if (issued_cnt !== 8'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", issued_cnt); end
        rst_n = 1'b1;
        tick();
        tests++; if (enc_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", enc_ready); end
    endtask

    task automatic test_single;
        push(2'd1, 8'd3, 8'd7, 8'd5);
        tests++; if (level !== 5'd1) begin fails++; $display("FAIL single_level: got %0d want 1", level); end
        run = 1'b1;
        tick();
        tests++; if (instr !== 32'hFF00_0000) begin fails++; $display("FAIL single_t1: got %h want ff000000", instr); end
        tick();
        tests++; if (instr !== 32'h0103_0705) begin fails++; $display("FAIL single_instr: got %h want 01030705", instr); end
        tick();
        tests++; if (instr !== 32'hFF03_0000 || done !== 1'b0) begin fails++; $display("FAIL single_drain1: got %h/%b want ff030000/0", instr, done); end
        tick();
        tests++; if (instr !== 32'hFF03_0000 || done !== 1'b1) begin fails++; $display("FAIL single_drain2: got %h/%b want ff030000/1", instr, done); end
        tick();
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL single_idle: got busy %b done %b want 0 0", busy, done); end
        tests++; if (issued_cnt !== 8'd1) begin fails++; $display("FAIL single_cnt: got %0d want 1", issued_cnt); end
        run = 1'b0;
    endtask

    task automatic test_hazard;
        push(2'd1, 8'd4, 8'd2, 8'd1);
        push(2'd2, 8'd5, 8'd0, 8'd4);
        run = 1'b1;
        tick();
        tick();
        tests++; if (instr !== 32'h0104_0201) begin fails++; $display("FAIL hz_add: got %h want 01040201", instr); end
        tick();
        tests++; if (instr !== 32'hFF04_0000 || busy !== 1'b1) begin fails++; $display("FAIL hz_bubble: got %h/%b want ff040000/1", instr, busy); end
        tick();
        tests++; if (instr !== 32'h0205_0004) begin fails++; $display("FAIL hz_fetch: got %h want 02050004", instr); end
        wait_done(10, "hz_done");
        tick();
        tests++; if (pmem[5] !== 8'd3) begin fails++; $display("FAIL hz_pmem5: got %0d want 3", pmem[5]); end
        tests++; if (issued_cnt !== 8'd3) begin fails++; $display("FAIL hz_cnt: got %0d want 3", issued_cnt); end
        run = 1'b0;
    endtask

    task automatic test_full;
        enc_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            enc_op    = 2'd0;
            enc_dst   = 8'(10 + i);
            enc_src_b = 8'hFF;
            enc_src_a = 8'(i + 1);
            tick();
        end
        enc_op = 2'd1; enc_dst = 8'h77; enc_src_b = 8'd9; enc_src_a = 8'd9;
        tests++; if (enc_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", enc_ready); end
        tests++; if (level !== 5'(DEPTH)) begin fails++; $display("FAIL full_level: got %0d want %0d", level, DEPTH); end
        tick();
        tests++; if (level !== 5'(DEPTH)) begin fails++; $display("FAIL full_reject: got %0d want %0d", level, DEPTH); end
        run = 1'b1;
        tick();
        tests++; if (enc_ready !== 1'b1) begin fails++; $display("FAIL full_ready_pop: got %b want 1", enc_ready); end
        tick();
        tests++; if (level !== 5'(DEPTH)) begin fails++; $display("FAIL full_pushpop: got %0d want %0d", level, DEPTH); end
        enc_valid = 1'b0;
        run = 1'b0;
        wait_done(10, "full_stop_done");
        tests++; if (level !== 5'(DEPTH)) begin fails++; $display("FAIL full_keep: got %0d want %0d", level, DEPTH); end
        run = 1'b1;
        wait_done(60, "full_done");
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL full_empty: got %0d want 0", level); end
        tests++; if (issued_cnt !== 8'd12) begin fails++; $display("FAIL full_cnt: got %0d want 12", issued_cnt); end
        tick();
        tests++; if (pmem[8'h77] !== 8'd18 || pmem[10] !== 8'd1) begin fails++; $display("FAIL full_pmem: got %0d,%0d want 18,1", pmem[8'h77], pmem[10]); end
        run = 1'b0;
    endtask

    task automatic test_reserved;
        push(2'd1, 8'h40, 8'd1, 8'd1);
        push(2'd3, 8'h41, 8'd1, 8'd1);
        tests++; if (level !== 5'd1) begin fails++; $display("FAIL rsvd_level: got %0d want 1", level); end
        run = 1'b1;
        wait_done(10, "rsvd_done");
        tests++; if (issued_cnt !== 8'd13) begin fails++; $display("FAIL rsvd_cnt: got %0d want 13", issued_cnt); end
        tick();
    endtask

    task automatic test_drain_push;
        push(2'd1, 8'h20, 8'd1, 8'd1);
        tick();
        tick();
        tests++; if (instr !== 32'h0120_0101) begin fails++; $display("FAIL dp_first: got %h want 01200101", instr); end
        enc_valid = 1'b1; enc_op = 2'd1; enc_dst = 8'h21; enc_src_b = 8'd2; enc_src_a = 8'd2;
        tick();
        enc_valid = 1'b0;
        tests++; if (busy !== 1'b1 || level !== 5'd1) begin fails++; $display("FAIL dp_drain1: got busy %b level %0d want 1 1", busy, level); end
        tick();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL dp_drain2: got done %b want 1", done); end
        tick();
        tick();
        tick();
        tests++; if (instr !== 32'h0121_0202) begin fails++; $display("FAIL dp_second: got %h want 01210202", instr); end
        wait_done(10, "dp_done");
        tests++; if (issued_cnt !== 8'd15) begin fails++; $display("FAIL dp_cnt: got %0d want 15", issued_cnt); end
        run = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit bad;
        enc_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            enc_op = 2'd1; enc_dst = 8'(8'h30 + i); enc_src_b = 8'd1; enc_src_a = 8'(i);
            tick();
        end
        enc_valid = 1'b0;
        run = 1'b1;
        tick();
        tick();
        tests++; if (level !== 5'd5 || instr !== 32'h0130_0100) begin fails++; $display("FAIL rm_pre: got level %0d instr %h want 5 01300100", level, instr); end
        #3;
        rst_n = 1'b0;
        #1;
        tests++; if (instr !== 32'hFF00_0000) begin fails++; $display("FAIL rm_instr: got %h want ff000000", instr); end
        tests++; if (level !== 5'd0 || busy !== 1'b0 || issued_cnt !== 8'd0) begin fails++; $display("FAIL rm_state: got level %0d busy %b cnt %0d want 0 0 0", level, busy, issued_cnt); end
        bad = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (done !== 1'b0 || instr !== 32'hFF00_0000) bad = 1'b1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done !== 1'b0 || instr !== 32'hFF00_0000) bad = 1'b1;
        end
        tests++; if (bad) begin fails++; $display("FAIL rm_after: got done or real instr after reset want none"); end
        tests++; if (enc_ready !== 1'b1 || level !== 5'd0) begin fails++; $display("FAIL rm_ready: got ready %b level %0d want 1 0", enc_ready, level); end
        run = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) pmem[i] = 8'd0;
        rst_n     = 1'b0;
        run       = 1'b0;
        enc_valid = 1'b0;
        enc_op    = 2'd0;
        enc_dst   = 8'd0;
        enc_src_b = 8'd0;
        enc_src_a = 8'd0;
        test_reset();
        test_single();
        test_hazard();
        test_full();
        test_reserved();
        test_drain_push();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
